// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width common to the transmitter and the arbiter,
// plus the arbiter FSM state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStart    = 2'd1,
        StWaitDone = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first set request at or after
// the pointer (wrapping) and returns it one-hot and as an index.
module rr_picker #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_k;
    logic             w_found;

    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        w_k     = '0;
        w_found = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            w_k = IDX_W'((32'(i_ptr) + off) % N_REQ);
            if (!w_found && i_req[w_k]) begin
                w_found     = 1'b1;
                o_pick[w_k] = 1'b1;
                o_idx       = w_k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers.
// Optional START-phase timeout with sticky o_err when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned DATA_W  = UART_DATA_W,
    parameter  int unsigned TIMEOUT = 16,
    localparam int unsigned IDX_W   = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_grant,
    output logic [IDX_W-1:0]        o_owner,
    output logic                    o_tx_start,
    output logic [DATA_W-1:0]       o_tx_data,
    input  logic                    i_tx_busy,
    output logic                    o_active,
    output logic                    o_err
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be 2..8");
    end
    if (DATA_W != UART_DATA_W) begin : g_bad_data_w
        $error("uart_tx_arbiter: DATA_W must match the transmitter width");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [N_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]  r_owner;
    logic [DATA_W-1:0] r_data;
    logic [N_REQ-1:0]  w_pick;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_grant_go;
    logic              w_timeout;
    logic              w_err;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_rr_picker (
        .i_req  (i_req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_idx)
    );

    // A busy transmitter in IDLE (e.g. after a mid-frame reset) blocks any grant.
    assign w_grant_go = (r_state == StIdle) && (|i_req) && !i_tx_busy;

    always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_pick[k]) begin
                w_sel_data = i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle:     if (w_grant_go) w_next_state = StStart;
            StStart: begin
                if (i_tx_busy) begin
                    w_next_state = StWaitDone;
                end else if (w_timeout) begin
                    w_next_state = StIdle;
                end
            end
            StWaitDone: if (!i_tx_busy) w_next_state = StIdle;
            default:    w_next_state = StIdle;
        endcase
    end

    always_comb begin
        o_tx_start = (r_state == StStart);
        o_active   = (r_state != StIdle);
        o_grant    = r_grant;
        o_owner    = r_owner;
        o_tx_data  = r_data;
        o_err      = w_err;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_owner <= '0;
            r_data  <= '0;
        end else begin
            r_grant <= w_grant_go ? w_pick : '0;
            if (w_grant_go) begin
                r_owner <= w_idx;
                r_data  <= w_sel_data;
                r_ptr   <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // START lasts exactly TIMEOUT cycles when busy never rises.
    assign w_timeout = (r_state == StStart) && !i_tx_busy && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_err     = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == StStart) ? r_cnt + 1'b1 : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the transmitter's busy line is driven by hand.
// The timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 16;

    logic                    i_clk = 1'b0;
    logic                    i_rst_n;
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*DATA_W-1:0] i_data;
    logic [N_REQ-1:0]        o_grant;
    logic [1:0]              o_owner;
    logic                    o_tx_start;
    logic [DATA_W-1:0]       o_tx_data;
    logic                    i_tx_busy;
    logic                    o_active;
    logic                    o_err;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_grant    (o_grant),
        .o_owner    (o_owner),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_busy  (i_tx_busy),
        .o_active   (o_active),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".grant"}, 32'(o_grant), 32'h0);
        check({tag, ".start"}, 32'(o_tx_start), 32'h0);
        check({tag, ".active"}, 32'(o_active), 32'h0);
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [7:0] d,
                               input logic [1:0] own);
        check({tag, ".grant"}, 32'(o_grant), 32'(g));
        check({tag, ".data"}, 32'(o_tx_data), 32'(d));
        check({tag, ".owner"}, 32'(o_owner), 32'(own));
        check({tag, ".start"}, 32'(o_tx_start), 32'h1);
        check({tag, ".active"}, 32'(o_active), 32'h1);
    endtask

    // Busy rises right after the grant, falls one cycle later; ends on the IDLE gap cycle.
    task automatic run_frame(input string tag);
        i_tx_busy = 1'b1;
        tick();
        check({tag, ".wait_start"}, 32'(o_tx_start), 32'h0);
        check({tag, ".wait_active"}, 32'(o_active), 32'h1);
        check({tag, ".pulse"}, 32'(o_grant), 32'h0);
        i_tx_busy = 1'b0;
        tick();
        check_idle_outputs({tag, ".gap"});
        tick();
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_req     = '0;
        i_tx_busy = 1'b0;
        i_data    = {8'h44, 8'h43, 8'h42, 8'h41};
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset.data", 32'(o_tx_data), 32'h0);
        check("reset.owner", 32'(o_owner), 32'h0);
        check("reset.err", 32'(o_err), 32'h0);

        // Single request from requester 0
        i_rst_n = 1'b1;
        i_req   = 4'b0001;
        tick();
        check_grant("single", 4'b0001, 8'h41, 2'd0);
        i_req = 4'b0000;
        tick();
        check("single.pulse", 32'(o_grant), 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("single.hold_start", 32'(o_tx_start), 32'h1);
        check("single.hold_data", 32'(o_tx_data), 32'h41);
        i_tx_busy = 1'b1;
        tick();
        check("single.start_drop", 32'(o_tx_start), 32'h0);
        check("single.busy_active", 32'(o_active), 32'h1);

        // Request raised and withdrawn during WAIT_DONE
        i_req = 4'b0100;
        tick();
        tick();
        check("withdraw.no_grant", 32'(o_grant), 32'h0);
        i_req = 4'b0000;
        tick();
        i_tx_busy = 1'b0;
        tick();
        check("single.active_drop", 32'(o_active), 32'h0);
        tick();
        check_idle_outputs("withdraw.idle");
        tick();
        check_idle_outputs("withdraw.idle2");

        // Busy already high in IDLE blocks the grant; ptr is 1 here
        i_tx_busy = 1'b1;
        i_req     = 4'b0010;
        tick();
        check_idle_outputs("busy_idle.1");
        tick();
        tick();
        check_idle_outputs("busy_idle.3");
        i_tx_busy = 1'b0;
        tick();
        check_grant("busy_idle.grant", 4'b0010, 8'h42, 2'd1);
        i_req     = 4'b0000;
        i_tx_busy = 1'b1;
        tick();
        check("busy_idle.wait", 32'(o_active), 32'h1);

        // Mid-frame reset with transmitter still busy; ptr was 2
        i_rst_n = 1'b0;
        tick();
        check_idle_outputs("midrst");
        check("midrst.data", 32'(o_tx_data), 32'h0);
        check("midrst.owner", 32'(o_owner), 32'h0);
        i_rst_n = 1'b1;
        i_req   = 4'b1111;
        i_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick();
        check_idle_outputs("midrst.blocked1");
        tick();
        check_idle_outputs("midrst.blocked2");
        i_tx_busy = 1'b0;
        tick();
        // ptr restarted at 0, so requester 0 wins first
        check_grant("rr.0", 4'b0001, 8'hA0, 2'd0);
        run_frame("rr.f0");
        check_grant("rr.1", 4'b0010, 8'hA1, 2'd1);
        run_frame("rr.f1");
        check_grant("rr.2", 4'b0100, 8'hA2, 2'd2);
        run_frame("rr.f2");
        check_grant("rr.3", 4'b1000, 8'hA3, 2'd3);
        run_frame("rr.f3");
        check_grant("rr.wrap", 4'b0001, 8'hA0, 2'd0);
        i_req = 4'b0000;
        run_frame("rr.f4");
        check_idle_outputs("rr.done");

`ifdef UART_ARB_TIMEOUT_EN
        // Busy never rises: START lasts TIMEOUT cycles, then o_err sticks; ptr is 1
        i_req  = 4'b0100;
        i_data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        check_grant("tmo.grant", 4'b0100, 8'h12, 2'd2);
        i_req = 4'b1000;
        for (int i = 0; i < 15; i++) tick();
        check("tmo.start_held", 32'(o_tx_start), 32'h1);
        check("tmo.err_before", 32'(o_err), 32'h0);
        tick();
        check("tmo.start_drop", 32'(o_tx_start), 32'h0);
        check("tmo.active_drop", 32'(o_active), 32'h0);
        check("tmo.err_set", 32'(o_err), 32'h1);
        tick();
        check_grant("tmo.next", 4'b1000, 8'h13, 2'd3);
        i_req = 4'b0000;
        run_frame("tmo.f");
        check("tmo.err_sticky", 32'(o_err), 32'h1);
        i_rst_n = 1'b0;
        tick();
        check("tmo.err_cleared", 32'(o_err), 32'h0);
        i_rst_n = 1'b1;
`else
        check("err.tied_low", 32'(o_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
